modulo_varredura_linha: RTL and testbench
=========================================

MODULO_VARREDURA_LINHA -- requirements
Module: modulo_varredura_linha

Interface
REQ-001 SHALL have parameter ROWS, default 7: number of matrix rows scanned (2..2**COORD_W).
REQ-002 SHALL have parameter COORD_W, default 3: width of the row coordinate.
REQ-003 SHALL have parameter DWELL, default 1000: clk cycles each row stays active (DWELL >= 2).
REQ-004 SHALL have parameter BLANK, default 2: clk cycles with all rows off between rows (BLANK >= 1).
REQ-005 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port en  input  1  scan enable; 0 requests stop at the next row boundary.
REQ-008 SHALL have port coord_in  input  COORD_W  requested row coordinate.
REQ-009 SHALL have port load  input  1  one-cycle strobe capturing coord_in.
REQ-010 SHALL have port row_n  output  ROWS  one-hot-low row drive, bit i low = row i lit.
REQ-011 SHALL have port cur_row  output  COORD_W  index of the row currently driven.
REQ-012 SHALL have port hit  output  1  high while the driven row equals the captured coordinate.
REQ-013 SHALL have port coord_err  output  1  sticky: last load had coord_in >= ROWS.
REQ-014 SHALL have port frame_tick  output  1  one-cycle pulse when the row index wraps ROWS-1 -> 0.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, GAP.
REQ-016 SHALL hold IDLE with row_n all ones until en=1; next cycle enters DRIVE at row 0.
REQ-017 SHALL, in DRIVE, hold row_n[cur_row]=0 and all other bits 1 for exactly DWELL cycles, then enter GAP.
REQ-018 SHALL, in GAP, drive row_n all ones for exactly BLANK cycles, then advance cur_row and enter DRIVE.
REQ-019 SHALL advance cur_row from ROWS-1 to 0 (wrap), never to values >= ROWS, and pulse frame_tick in the first cycle of DRIVE for row 0 of every frame except the first after IDLE.
REQ-020 SHALL, on en=0, finish the current DRIVE/GAP pair and return to IDLE instead of advancing; cur_row resets to 0 on IDLE entry.
REQ-021 SHALL capture coord_in into an internal register on load=1 when coord_in < ROWS; the new value affects hit from the next cycle.
REQ-022 SHALL, on load=1 with coord_in >= ROWS, keep the previous captured coordinate and set coord_err=1.
REQ-023 SHALL clear coord_err on the next valid load.
REQ-024 SHALL assert hit only in DRIVE and only when cur_row equals the captured coordinate; hit=0 in IDLE and GAP.
REQ-025 SHALL accept load in any state, including mid-DWELL, without disturbing scan timing.
REQ-026 SHALL use a dwell/blank counter of width clog2(max(DWELL,BLANK)); no outputs are combinationally dependent on inputs.

Reset
REQ-027 SHALL, while rst_n=0, force state IDLE, row_n all ones, cur_row=0, hit=0, coord_err=0, frame_tick=0, captured coordinate=0, counters=0.
REQ-028 SHALL, on rst_n asserted mid-DRIVE, blank all rows immediately (asynchronously).
REQ-029 SHALL resume from IDLE on the first rising clk edge after rst_n deasserts.

Configuration
REQ-030 SHALL support macro VARREDURA_PISCA_EN: when defined, the captured row is lit only during frames where a 5-bit frame counter bit 4 is 1 (blinks every 16 frames) while hit still follows REQ-024; when undefined, no frame counter exists and the captured row is lit every frame.

Verification
REQ-031 SHALL cover: ROWS=7, DWELL=4, BLANK=2, en=1 after reset -> row_n=7'b1111110 for 4 cycles, 7'b1111111 for 2, then 7'b1111101; frame_tick pulse when row 0 returns after 42 cycles.
REQ-032 SHALL cover: load coord_in=3 mid-scan -> hit=1 exactly during the 4 DRIVE cycles of row 3, 0 elsewhere.
REQ-033 SHALL cover: load coord_in=7 with ROWS=7 -> coord_err=1, hit still tracks prior coordinate 3; then load coord_in=2 -> coord_err=0.
REQ-034 SHALL cover: en dropped during DRIVE of row 4 -> row 4 completes DWELL+BLANK, FSM in IDLE, row_n=7'b1111111, cur_row=0.
REQ-035 SHALL cover: rst_n pulsed low during DRIVE of row 5 -> row_n=7'b1111111 in the same cycle, all outputs at reset values.
REQ-036 SHALL cover: with VARREDURA_PISCA_EN, captured row 1 dark for frames 0-15 and lit for frames 16-31, other rows lit every frame.

Source files
------------

// File: rtl/modulo_varredura_linha.sv
// modulo_varredura_linha
//
// Row scanner for a multiplexed display matrix. Rows are lit one at a time
// (active-low drive) for DWELL clk cycles, followed by BLANK cycles with every
// row off, then the next row is selected. A coordinate register captured
// through load/coord_in marks one row; hit reports when that row is driven.
//
// Build option: VARREDURA_PISCA_EN
//   defined   -> a 5-bit frame counter makes the captured row blink: it is
//                lit only in frames where frame counter bit 4 is 1.
//   undefined -> no frame counter; the captured row is lit every frame.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   en          in   scan enable; low stops the scan at the next row boundary
//   coord_in    in   [COORD_W] requested row coordinate
//   load        in   one-cycle strobe capturing coord_in
//   row_n       out  [ROWS] one-hot-low row drive (bit i low = row i lit)
//   cur_row     out  [COORD_W] index of the row being scanned
//   hit         out  driven row equals the captured coordinate (DRIVE only)
//   coord_err   out  sticky: last load carried coord_in >= ROWS
//   frame_tick  out  one-cycle pulse when the scan wraps ROWS-1 -> 0
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | all rows off, cur_row = 0, waiting for en
// DRIVE | row cur_row lit for DWELL cycles
// GAP   | all rows off for BLANK cycles, then advance or stop

module modulo_varredura_linha #(
  parameter int ROWS    = 7,
  parameter int COORD_W = 3,
  parameter int DWELL   = 1000,
  parameter int BLANK   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [COORD_W-1:0] coord_in,
  input  logic               load,
  output logic [ROWS-1:0]    row_n,
  output logic [COORD_W-1:0] cur_row,
  output logic               hit,
  output logic               coord_err,
  output logic               frame_tick
);

  localparam int                 MAX_T    = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int                 CNT_W    = $clog2(MAX_T);
  localparam logic [CNT_W-1:0]   DWELL_LD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0]   BLANK_LD = CNT_W'(BLANK - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(ROWS - 1);
  // one extra bit so ROWS = 2**COORD_W is still representable
  localparam logic [COORD_W:0]   ROWS_EXT = (COORD_W + 1)'(ROWS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [COORD_W-1:0] cap;
  logic               gap_done;
  logic               wrap_now;
  logic               row_dark;

  // last GAP cycle: decides between advancing and returning to IDLE
  assign gap_done = (state == GAP) && (cnt == '0);
  assign wrap_now = gap_done && en && (cur_row == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_row    <= '0;
      frame_tick <= 1'b0;
    end else begin
      // only the GAP -> DRIVE(row 0) transition pulses; the first row 0
      // after IDLE comes from the IDLE branch and never ticks
      frame_tick <= wrap_now;
      case (state)
        IDLE: begin
          cur_row <= '0;
          cnt     <= '0;
          if (en) begin
            state <= DRIVE;
            cnt   <= DWELL_LD;
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            state <= GAP;
            cnt   <= BLANK_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!en) begin
            state   <= IDLE;
            cur_row <= '0;
          end else begin
            state <= DRIVE;
            cnt   <= DWELL_LD;
            if (cur_row == LAST_ROW) cur_row <= '0;
            else                     cur_row <= cur_row + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          cur_row <= '0;
        end
      endcase
    end
  end

  // coordinate capture is independent of the scan so a load never
  // perturbs row timing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap       <= '0;
      coord_err <= 1'b0;
    end else if (load) begin
      if ({1'b0, coord_in} < ROWS_EXT) begin
        cap       <= coord_in;
        coord_err <= 1'b0;
      end else begin
        coord_err <= 1'b1;
      end
    end
  end

`ifdef VARREDURA_PISCA_EN
  logic [4:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        frame_cnt <= '0;
    else if (wrap_now) frame_cnt <= frame_cnt + 1'b1;
  end

  assign row_dark = (cur_row == cap) && !frame_cnt[4];
`else
  assign row_dark = 1'b0;
`endif

  // outputs decode registered state only; reset forces IDLE, which blanks
  // every row asynchronously
  always_comb begin
    row_n = '1;
    if ((state == DRIVE) && !row_dark) begin
      for (int i = 0; i < ROWS; i++) begin
        if (cur_row == COORD_W'(i)) row_n[i] = 1'b0;
      end
    end
  end

  assign hit = (state == DRIVE) && (cur_row == cap);

endmodule

// File: tb/tb_modulo_varredura_linha.sv
module tb_modulo_varredura_linha;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] coord_in;
  logic       load;
  logic [6:0] row_n;
  logic [2:0] cur_row;
  logic       hit;
  logic       coord_err;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;
  int c      = 0;  // sample index since the scan left IDLE
  int capexp = 0;

  always #5 clk = ~clk;

  modulo_varredura_linha #(.ROWS(7), .COORD_W(3), .DWELL(4), .BLANK(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .coord_in(coord_in), .load(load),
    .row_n(row_n), .cur_row(cur_row), .hit(hit), .coord_err(coord_err),
    .frame_tick(frame_tick)
  );

  // expected waveform: 6 cycles per row (4 lit + 2 blank), 7 rows per frame
  function automatic logic [6:0] exp_row(input int cc);
    logic [6:0] one;
    int r;
    one = 7'b1;
    r = (cc / 6) % 7;
    if ((cc % 6) < 4) return ~(one << r);
    return 7'h7F;
  endfunction

  function automatic logic [2:0] exp_cur(input int cc);
    return 3'((cc / 6) % 7);
  endfunction

  function automatic logic exp_hit(input int cc, input int cp);
    return ((cc % 6) < 4) && (((cc / 6) % 7) == cp);
  endfunction

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; coord_in = 3'd0;
    step; step;
    checks++; if (row_n !== 7'h7F) begin errors++; $display("FAIL reset_row_n: got %b expected %b", row_n, 7'h7F); end
    checks++; if (cur_row !== 3'd0) begin errors++; $display("FAIL reset_cur_row: got %0d expected 0", cur_row); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b expected 0", hit); end
    checks++; if (coord_err !== 1'b0) begin errors++; $display("FAIL reset_coord_err: got %b expected 0", coord_err); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick: got %b expected 0", frame_tick); end
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step;
      checks++; if (row_n !== 7'h7F) begin errors++; $display("FAIL idle_hold_row_n: got %b expected %b", row_n, 7'h7F); end
    end
  endtask

  task automatic test_scan;
    en = 1'b1; c = 0; capexp = 0;
    for (int n = 0; n < 48; n++) begin
      step;
      checks++; if (row_n !== exp_row(c)) begin errors++; $display("FAIL scan_row_n c=%0d: got %b expected %b", c, row_n, exp_row(c)); end
      checks++; if (cur_row !== exp_cur(c)) begin errors++; $display("FAIL scan_cur_row c=%0d: got %0d expected %0d", c, cur_row, exp_cur(c)); end
      checks++; if (frame_tick !== (c == 42)) begin errors++; $display("FAIL scan_frame_tick c=%0d: got %b expected %b", c, frame_tick, c == 42); end
      checks++; if (hit !== exp_hit(c, capexp)) begin errors++; $display("FAIL scan_hit c=%0d: got %b expected %b", c, hit, exp_hit(c, capexp)); end
      c++;
    end
  endtask

  task automatic test_load_hit;
    int hits;
    hits = 0;
    load = 1'b1; coord_in = 3'd3; capexp = 3;
    for (int n = 0; n < 42; n++) begin
      step;
      load = 1'b0;
      checks++; if (hit !== exp_hit(c, capexp)) begin errors++; $display("FAIL load_hit c=%0d: got %b expected %b", c, hit, exp_hit(c, capexp)); end
      checks++; if (row_n !== exp_row(c)) begin errors++; $display("FAIL load_row_n c=%0d: got %b expected %b", c, row_n, exp_row(c)); end
      if (hit === 1'b1) hits++;
      c++;
    end
    checks++; if (hits != 4) begin errors++; $display("FAIL load_hit_count: got %0d expected 4", hits); end
  endtask

  task automatic test_coord_err;
    load = 1'b1; coord_in = 3'd7;
    step;
    load = 1'b0;
    checks++; if (coord_err !== 1'b1) begin errors++; $display("FAIL coord_err_set: got %b expected 1", coord_err); end
    c++;
    for (int n = 0; n < 42; n++) begin
      step;
      checks++; if (hit !== exp_hit(c, 3)) begin errors++; $display("FAIL err_hit_keeps3 c=%0d: got %b expected %b", c, hit, exp_hit(c, 3)); end
      c++;
    end
    checks++; if (coord_err !== 1'b1) begin errors++; $display("FAIL coord_err_sticky: got %b expected 1", coord_err); end
    load = 1'b1; coord_in = 3'd2; capexp = 2;
    step;
    load = 1'b0;
    checks++; if (coord_err !== 1'b0) begin errors++; $display("FAIL coord_err_clear: got %b expected 0", coord_err); end
    c++;
    for (int n = 0; n < 42; n++) begin
      step;
      checks++; if (hit !== exp_hit(c, capexp)) begin errors++; $display("FAIL hit_after_2 c=%0d: got %b expected %b", c, hit, exp_hit(c, capexp)); end
      c++;
    end
  endtask

  task automatic test_stop;
    int guard;
    guard = 0;
    while (!(((c / 6) % 7) == 4 && (c % 6) == 1) && guard < 100) begin
      step;
      checks++; if (row_n !== exp_row(c)) begin errors++; $display("FAIL pre_stop_row_n c=%0d: got %b expected %b", c, row_n, exp_row(c)); end
      c++; guard++;
    end
    if (guard >= 100) begin
      checks++; errors++;
      $display("FAIL stop_reach_row4: got timeout expected row 4 within 100 cycles");
    end
    en = 1'b0;
    while ((c % 6) != 0) begin
      step;
      checks++; if (row_n !== exp_row(c)) begin errors++; $display("FAIL stop_finish_row_n c=%0d: got %b expected %b", c, row_n, exp_row(c)); end
      checks++; if (cur_row !== 3'd4) begin errors++; $display("FAIL stop_finish_cur_row c=%0d: got %0d expected 4", c, cur_row); end
      c++;
    end
    for (int n = 0; n < 3; n++) begin
      step;
      checks++; if (row_n !== 7'h7F) begin errors++; $display("FAIL stop_idle_row_n: got %b expected %b", row_n, 7'h7F); end
      checks++; if (cur_row !== 3'd0) begin errors++; $display("FAIL stop_idle_cur_row: got %0d expected 0", cur_row); end
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL stop_idle_hit: got %b expected 0", hit); end
      checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL stop_idle_frame_tick: got %b expected 0", frame_tick); end
    end
  endtask

  task automatic test_reset_mid;
    en = 1'b1; load = 1'b1; coord_in = 3'd7; c = 0;
    while (c < 31) begin
      step;
      load = 1'b0;
      checks++; if (row_n !== exp_row(c)) begin errors++; $display("FAIL restart_row_n c=%0d: got %b expected %b", c, row_n, exp_row(c)); end
      checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL restart_no_tick c=%0d: got %b expected 0", c, frame_tick); end
      c++;
    end
    checks++; if (coord_err !== 1'b1) begin errors++; $display("FAIL restart_coord_err: got %b expected 1", coord_err); end
    checks++; if (row_n !== 7'b1011111) begin errors++; $display("FAIL row5_lit: got %b expected %b", row_n, 7'b1011111); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (row_n !== 7'h7F) begin errors++; $display("FAIL async_rst_row_n: got %b expected %b", row_n, 7'h7F); end
    checks++; if (cur_row !== 3'd0) begin errors++; $display("FAIL async_rst_cur_row: got %0d expected 0", cur_row); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL async_rst_hit: got %b expected 0", hit); end
    checks++; if (coord_err !== 1'b0) begin errors++; $display("FAIL async_rst_coord_err: got %b expected 0", coord_err); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL async_rst_frame_tick: got %b expected 0", frame_tick); end
    @(negedge clk);
    rst_n = 1'b1;
    step;
    checks++; if (row_n !== 7'b1111110) begin errors++; $display("FAIL resume_row_n: got %b expected %b", row_n, 7'b1111110); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL resume_hit_cap0: got %b expected 1", hit); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL resume_frame_tick: got %b expected 0", frame_tick); end
  endtask

  task automatic test_blink;
    logic [6:0] e;
    load = 1'b1; coord_in = 3'd1; en = 1'b1; capexp = 1;
    for (c = 0; c < 32 * 42; c++) begin
      step;
      load = 1'b0;
      e = exp_row(c);
      if (((c / 6) % 7) == 1 && (c / 42) < 16) e = 7'h7F;
      checks++; if (row_n !== e) begin errors++; $display("FAIL blink_row_n c=%0d: got %b expected %b", c, row_n, e); end
      checks++; if (hit !== exp_hit(c, capexp)) begin errors++; $display("FAIL blink_hit c=%0d: got %b expected %b", c, hit, exp_hit(c, capexp)); end
    end
  endtask

  initial begin
    test_reset;
`ifdef VARREDURA_PISCA_EN
    test_blink;
`else
    test_scan;
    test_load_hit;
    test_coord_err;
    test_stop;
    test_reset_mid;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
